pen_hit_detector: RTL

//   Upstream of the LED driver: turns the raw light-pen photodiode input into the write-enable

---
 rtl/pen_hit_detector_pkg.sv | 21 ++
 rtl/pen_hit_detector_onehot8_enc.sv | 20 ++
 rtl/pen_hit_detector.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/pen_hit_detector_pkg.sv
// Shared definitions for the light-pen hit detector: FSM state encoding,
// default slot timing and a small sizing helper.
package pen_hit_detector_pkg;

    typedef enum logic [1:0] {
        PH_IDLE   = 2'd0,
        PH_SETTLE = 2'd1,
        PH_SAMPLE = 2'd2,
        PH_DECIDE = 2'd3
    } ph_state_t;

    localparam int PH_SETTLE_CYC_DEF = 8;
    localparam int PH_WINDOW_CYC_DEF = 16;
    localparam int PH_THRESH_DEF     = 12;
    localparam int PH_LOCK_SLOTS_DEF = 64;

    function automatic int ph_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pen_hit_detector_onehot8_enc.sv
// 8-bit one-hot to 3-bit binary encoder with a flag that is high only when
// exactly one input bit is set.
module onehot8_enc (
    input  logic [7:0] onehot,
    output logic [2:0] idx,
    output logic       valid
);

    // Encode the highest set bit and flag whether the input is truly one-hot
    always_comb begin
        idx   = 3'd0;
        valid = $onehot(onehot);
        for (int i = 0; i < 8; i++) begin
            if (onehot[i]) begin
                idx = 3'(i);
            end
        end
    end

endmodule

// File: rtl/pen_hit_detector.sv
// Light-pen hit detector: synchronises the photodiode, samples it in a
// window after the LED has settled, majority-votes the window and pulses
// the LED RAM write strobe while the hit slot's address is still current.
// Repeat hits on the same pixel are suppressed for a number of slots.
module pen_hit_detector
    import pen_hit_detector_pkg::*;
#(
    parameter int SETTLE_CYC = PH_SETTLE_CYC_DEF,
    parameter int WINDOW_CYC = PH_WINDOW_CYC_DEF,
    parameter int THRESH     = PH_THRESH_DEF,
    parameter int LOCK_SLOTS = PH_LOCK_SLOTS_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pen_raw,
    input  logic       pen_en,
    input  logic       slot_start,
    input  logic [7:0] scan_row,
    input  logic [7:0] scan_col,
    output logic       we,
    output logic [2:0] hit_row,
    output logic [2:0] hit_col,
    output logic       busy
);

    localparam int ONES_W = $clog2(WINDOW_CYC + 1);
    localparam int CNT_W  = $clog2(ph_max(SETTLE_CYC, WINDOW_CYC) + 1);
    localparam int LOCK_W = $clog2(LOCK_SLOTS + 1);

    ph_state_t         state;
    logic              pen_meta;
    logic              pen_s;
    logic [CNT_W-1:0]  cnt;
    logic [ONES_W-1:0] ones;
    logic [ONES_W-1:0] ones_final;
    logic [LOCK_W-1:0] lock_cnt;
    logic [2:0]        slot_row;
    logic [2:0]        slot_col;
    logic [2:0]        enc_row;
    logic [2:0]        enc_col;
    logic              row_valid;
    logic              col_valid;
    logic              start_ok;
    logic              suppress;
    logic              last_sample;
    logic              hit_now;

    onehot8_enc u_row_enc (
        .onehot (scan_row),
        .idx    (enc_row),
        .valid  (row_valid)
    );

    onehot8_enc u_col_enc (
        .onehot (scan_col),
        .idx    (enc_col),
        .valid  (col_valid)
    );

    // The decision is taken on the last SAMPLE edge so the strobe is already
    // registered high for the whole DECIDE cycle.
    assign start_ok    = pen_en & row_valid & col_valid;
    assign ones_final  = ones + ONES_W'(pen_s);
    assign suppress    = (lock_cnt != '0) && (slot_row == hit_row) && (slot_col == hit_col);
    assign last_sample = (state == PH_SAMPLE) && (cnt == CNT_W'(WINDOW_CYC - 1));
    assign hit_now     = last_sample && !slot_start && (ones_final >= ONES_W'(THRESH))
                         && pen_en && !suppress;

    // Two-flop synchroniser for the asynchronous comparator output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pen_meta <= 1'b0;
            pen_s    <= 1'b0;
        end else begin
            pen_meta <= pen_raw;
            pen_s    <= pen_meta;
        end
    end

    // Repeat-hit lockout: load on a hit, otherwise count down once per slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_cnt <= '0;
        end else if (hit_now) begin
            lock_cnt <= LOCK_W'(LOCK_SLOTS);
        end else if (slot_start && lock_cnt != '0) begin
            lock_cnt <= lock_cnt - LOCK_W'(1);
        end
    end

    // Slot FSM with settle/sample counting and registered strobe/coordinates
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= PH_IDLE;
            cnt      <= '0;
            ones     <= '0;
            slot_row <= 3'd0;
            slot_col <= 3'd0;
            we       <= 1'b0;
            hit_row  <= 3'd0;
            hit_col  <= 3'd0;
            busy     <= 1'b0;
        end else begin
            we <= 1'b0;
            if (slot_start) begin
                slot_row <= enc_row;
                slot_col <= enc_col;
            end
            if (slot_start && state != PH_DECIDE) begin
                cnt  <= '0;
                ones <= '0;
                if (start_ok) begin
                    state <= PH_SETTLE;
                    busy  <= 1'b1;
                end else begin
                    state <= PH_IDLE;
                    busy  <= 1'b0;
                end
            end else begin
                case (state)
                    PH_IDLE: begin
                        busy <= 1'b0;
                    end
                    PH_SETTLE: begin
                        if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
                            state <= PH_SAMPLE;
                            cnt   <= '0;
                            ones  <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    PH_SAMPLE: begin
                        ones <= ones_final;
                        if (last_sample) begin
                            state <= PH_DECIDE;
                            cnt   <= '0;
                            we    <= hit_now;
                            if (hit_now) begin
                                hit_row <= slot_row;
                                hit_col <= slot_col;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    PH_DECIDE: begin
                        cnt  <= '0;
                        ones <= '0;
                        if (slot_start && start_ok) begin
                            state <= PH_SETTLE;
                            busy  <= 1'b1;
                        end else begin
                            state <= PH_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= PH_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
